// File: rtl/stream_demux_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stream_demux_pkg
// Description : Shared constants, types and helpers for the 1:4 stream demux.
// Revision    : 1.0 - initial release
// ============================================================================
package stream_demux_pkg;

    // Number of output channels and the width of the channel selector.
    localparam int N_CH  = 4;
    localparam int SEL_W = 2;

    typedef logic [SEL_W-1:0] sel_t;

    // One-hot decode of a channel selector.
    function automatic logic [N_CH-1:0] sel_onehot(input sel_t sel);
        logic [N_CH-1:0] oh;
        oh = '0;
        oh[sel] = 1'b1;
        return oh;
    endfunction

endpackage : stream_demux_pkg
`default_nettype wire

// File: rtl/stream_slot.sv
`default_nettype none
// ============================================================================
// Module      : stream_slot
// Description : One-entry registered output stage with a load input, a
//               valid/ready drain handshake and a wrapping transfer counter.
// Revision    : 1.0 - initial release
// ============================================================================
module stream_slot #(
    parameter int W     = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [W-1:0]     data_i,
    input  logic             ready_i,
    output logic             valid_o,
    output logic [W-1:0]     data_o,
    output logic [CNT_W-1:0] cnt_o
);

    logic             valid_q, valid_d;
    logic [W-1:0]     data_q,  data_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             xfer;

    assign xfer = valid_q && ready_i;

    // Next state: a load refills the slot even while it drains; the data
    // register keeps its last value once the beat has left.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end else if (xfer) begin
            valid_d = 1'b0;
        end
        if (xfer) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Slot state registers; reset discards any in-flight beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign cnt_o   = cnt_q;

endmodule : stream_slot
`default_nettype wire

// File: rtl/stream_demux_1_4.sv
`default_nettype none
// ============================================================================
// Module      : stream_demux_1_4
// Description : Routes one valid/ready stream to one of four registered
//               output channels chosen per beat by in_sel. Each channel has
//               its own slot, so a stalled consumer only blocks its own beats.
// Revision    : 1.0 - initial release
// ============================================================================
module stream_demux_1_4
    import stream_demux_pkg::*;
#(
    parameter int W     = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    input  sel_t             in_sel,
    output logic [N_CH-1:0]  out_valid,
    input  logic [N_CH-1:0]  out_ready,
    output logic [W-1:0]     out_data0,
    output logic [W-1:0]     out_data1,
    output logic [W-1:0]     out_data2,
    output logic [W-1:0]     out_data3,
    output logic [CNT_W-1:0] xfer_cnt0,
    output logic [CNT_W-1:0] xfer_cnt1,
    output logic [CNT_W-1:0] xfer_cnt2,
    output logic [CNT_W-1:0] xfer_cnt3
);

    logic [N_CH-1:0]  load;
    logic [W-1:0]     slot_data [N_CH];
    logic [CNT_W-1:0] slot_cnt  [N_CH];
    logic             accept;

    // The selected slot can take a beat if it is empty or draining this
    // cycle. Deliberately independent of in_valid.
    assign in_ready = !rst && (!out_valid[in_sel] || out_ready[in_sel]);
    assign accept   = in_valid && in_ready;

    // Load decode: only the addressed slot loads, and only on an accept.
    always_comb begin
        load = '0;
        if (accept) begin
            load = sel_onehot(in_sel);
        end
    end

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_slot
            stream_slot #(
                .W     (W),
                .CNT_W (CNT_W)
            ) u_slot (
                .clk     (clk),
                .rst     (rst),
                .load_i  (load[gi]),
                .data_i  (in_data),
                .ready_i (out_ready[gi]),
                .valid_o (out_valid[gi]),
                .data_o  (slot_data[gi]),
                .cnt_o   (slot_cnt[gi])
            );
        end
    endgenerate

    assign out_data0 = slot_data[0];
    assign out_data1 = slot_data[1];
    assign out_data2 = slot_data[2];
    assign out_data3 = slot_data[3];
    assign xfer_cnt0 = slot_cnt[0];
    assign xfer_cnt1 = slot_cnt[1];
    assign xfer_cnt2 = slot_cnt[2];
    assign xfer_cnt3 = slot_cnt[3];

endmodule : stream_demux_1_4
`default_nettype wire

// File: tb/tb_stream_demux_1_4.sv
`default_nettype none
// ============================================================================
// Module      : tb_stream_demux_1_4
// Description : Self-checking bench for stream_demux_1_4 (vector table plus
//               hand-written multi-cycle sequences).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stream_demux_1_4;

    localparam int W     = 4;
    localparam int CNT_W = 8;
    localparam int N_VEC = 13;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_data;
    logic [1:0]       in_sel;
    logic [3:0]       out_valid;
    logic [3:0]       out_ready;
    logic [W-1:0]     out_data0, out_data1, out_data2, out_data3;
    logic [CNT_W-1:0] xfer_cnt0, xfer_cnt1, xfer_cnt2, xfer_cnt3;

    logic [W-1:0]     dd [4];
    logic [CNT_W-1:0] dc [4];

    assign dd[0] = out_data0;
    assign dd[1] = out_data1;
    assign dd[2] = out_data2;
    assign dd[3] = out_data3;
    assign dc[0] = xfer_cnt0;
    assign dc[1] = xfer_cnt1;
    assign dc[2] = xfer_cnt2;
    assign dc[3] = xfer_cnt3;

    stream_demux_1_4 #(.W(W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data0 (out_data0),
        .out_data1 (out_data1),
        .out_data2 (out_data2),
        .out_data3 (out_data3),
        .xfer_cnt0 (xfer_cnt0),
        .xfer_cnt1 (xfer_cnt1),
        .xfer_cnt2 (xfer_cnt2),
        .xfer_cnt3 (xfer_cnt3)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic             iv;
        logic [1:0]       sel;
        logic [W-1:0]     data;
        logic [3:0]       ordy;
        logic             chk_rdy;
        logic             exp_rdy;
        logic [3:0]       exp_v;
        logic [3:0][W-1:0]     exp_d;   // {ch3, ch2, ch1, ch0}
        logic [3:0][CNT_W-1:0] exp_c;   // {ch3, ch2, ch1, ch0}
    } vec_t;

    vec_t vecs [N_VEC];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic vec_t mk(input logic iv, input logic [1:0] sel,
                                input logic [W-1:0] data, input logic [3:0] ordy,
                                input logic chk_rdy, input logic exp_rdy,
                                input logic [3:0] exp_v, input logic [15:0] exp_d,
                                input logic [31:0] exp_c);
        vec_t v;
        v.iv = iv; v.sel = sel; v.data = data; v.ordy = ordy;
        v.chk_rdy = chk_rdy; v.exp_rdy = exp_rdy; v.exp_v = exp_v;
        v.exp_d = exp_d; v.exp_c = exp_c;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
        end
    endtask

    task automatic chk_all_state(input string tag, input logic [3:0] ev,
                                 input logic [3:0][W-1:0] ed,
                                 input logic [3:0][CNT_W-1:0] ec);
        chk({tag, " out_valid"}, 32'(out_valid), 32'(ev));
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("%s out_data%0d", tag, c), 32'(dd[c]), 32'(ed[c]));
            chk($sformatf("%s xfer_cnt%0d", tag, c), 32'(dc[c]), 32'(ec[c]));
        end
    endtask

    initial begin
        // Routing, per-channel stall, isolation and idle-with-x-select vectors.
        vecs[0]  = mk(1, 2'd0, 4'ha, 4'hF, 1, 1, 4'b0001, 16'h000a, 32'h00000000);
        vecs[1]  = mk(1, 2'd1, 4'hb, 4'hF, 1, 1, 4'b0010, 16'h00ba, 32'h00000001);
        vecs[2]  = mk(1, 2'd2, 4'hc, 4'hF, 1, 1, 4'b0100, 16'h0cba, 32'h00000101);
        vecs[3]  = mk(1, 2'd3, 4'hd, 4'hF, 1, 1, 4'b1000, 16'hdcba, 32'h00010101);
        vecs[4]  = mk(0, 2'd0, 4'h0, 4'hF, 1, 1, 4'b0000, 16'hdcba, 32'h01010101);
        vecs[5]  = mk(1, 2'd2, 4'h5, 4'hB, 1, 1, 4'b0100, 16'hd5ba, 32'h01010101);
        vecs[6]  = mk(1, 2'd2, 4'h6, 4'hB, 1, 0, 4'b0100, 16'hd5ba, 32'h01010101);
        vecs[7]  = mk(1, 2'd1, 4'h7, 4'hB, 1, 1, 4'b0110, 16'hd57a, 32'h01010101);
        vecs[8]  = mk(1, 2'd2, 4'h6, 4'hF, 1, 1, 4'b0100, 16'hd67a, 32'h01020201);
        vecs[9]  = mk(0, 2'd0, 4'h0, 4'hF, 1, 1, 4'b0000, 16'hd67a, 32'h01030201);
        vecs[10] = mk(1, 2'd0, 4'h9, 4'h0, 1, 1, 4'b0001, 16'hd679, 32'h01030201);
        vecs[11] = mk(0, 2'bxx, 4'hx, 4'h0, 0, 0, 4'b0001, 16'hd679, 32'h01030201);
        vecs[12] = mk(0, 2'd0, 4'h0, 4'h1, 1, 1, 4'b0000, 16'hd679, 32'h01030202);

        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_sel = '0; out_ready = 4'hF;
        @(posedge clk); @(posedge clk); #1;
        chk_all_state("reset", 4'b0000, '0, '0);
        chk("reset in_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < N_VEC; i++) begin
            in_valid  = vecs[i].iv;
            in_sel    = vecs[i].sel;
            in_data   = vecs[i].data;
            out_ready = vecs[i].ordy;
            #3;
            if (vecs[i].chk_rdy)
                chk($sformatf("v%0d in_ready", i), 32'(in_ready), 32'(vecs[i].exp_rdy));
            @(posedge clk); #1;
            chk_all_state($sformatf("v%0d", i), vecs[i].exp_v, vecs[i].exp_d, vecs[i].exp_c);
        end

        // Fill ch1 and ch2, then assert reset asynchronously mid-cycle.
        out_ready = 4'h0;
        in_valid = 1'b1; in_sel = 2'd1; in_data = 4'h3;
        @(posedge clk); #1;
        in_sel = 2'd2; in_data = 4'h4;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("prefill out_valid", 32'(out_valid), 32'b0110);
        #2 rst = 1'b1;
        #1;
        chk_all_state("async rst", 4'b0000, '0, '0);
        in_valid = 1'b1; in_sel = 2'd1; in_data = 4'h8;
        #1;
        chk("async rst in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        chk("rst held out_valid", 32'(out_valid), 32'd0);
        chk("rst held in_ready", 32'(in_ready), 32'd0);
        rst = 1'b0; in_valid = 1'b0; out_ready = 4'hF;

        // Back-to-back stream of 8 beats to ch3.
        for (int j = 1; j <= 8; j++) begin
            in_valid = 1'b1; in_sel = 2'd3; in_data = 4'(j);
            #3;
            chk($sformatf("stream%0d in_ready", j), 32'(in_ready), 32'd1);
            @(posedge clk); #1;
            chk($sformatf("stream%0d valid3", j), 32'(out_valid[3]), 32'd1);
            chk($sformatf("stream%0d data3", j), 32'(out_data3), 32'(j));
            chk($sformatf("stream%0d cnt3", j), 32'(xfer_cnt3), 32'(j - 1));
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("stream end valid3", 32'(out_valid[3]), 32'd0);
        chk("stream end cnt3", 32'(xfer_cnt3), 32'd8);

        // 257 transfers on ch0: counter wraps 255 -> 0 and ends at 1.
        for (int j = 1; j <= 257; j++) begin
            in_valid = 1'b1; in_sel = 2'd0; in_data = 4'(j);
            @(posedge clk); #1;
            if (j == 256) chk("wrap cnt0 at 255", 32'(xfer_cnt0), 32'd255);
            if (j == 257) chk("wrap cnt0 to 0", 32'(xfer_cnt0), 32'd0);
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("wrap final cnt0", 32'(xfer_cnt0), 32'd1);
        chk("wrap final valid", 32'(out_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_stream_demux_1_4
`default_nettype wire

// File: doc/stream_demux_1_4.md
Name: stream_demux_1_4

Overview:
- Demultiplexer that routes one valid/ready input stream to one of four valid/ready output channels, selected per beat by `in_sel`.
- Each output channel has a one-entry registered stage, so traffic to one channel never blocks the others.
- Sits between a single producer and four consumers.
- Counts completed output transfers per channel for debug and verification.

Parameters:
- W, 4, data width of each beat.
- CNT_W, 8, width of each per-channel transfer counter.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- rst  input  1  reset, asynchronous and active-high.
- in_valid  input  1  input beat present.
- in_ready  output  1  input beat can be accepted this cycle.
- in_data  input  W  input beat payload.
- in_sel  input  2  destination channel, 0..3; don't-care when in_valid=0.
- out_valid  output  4  bit i: channel i holds a beat.
- out_ready  input  4  bit i: consumer i accepts the beat this cycle.
- out_data0..out_data3  output  W each  channel payloads.
- xfer_cnt0..xfer_cnt3  output  CNT_W each  completed-transfer counts per channel.

Behaviour:
- Reset (asynchronous assert; release on a clk edge):
  - out_valid=0, all out_dataN=0, all xfer_cntN=0.
  - in_ready while rst is high is 0.
- Definitions:
  - Accept: in_valid && in_ready.
  - Output transfer i: out_valid[i] && out_ready[i].
- in_ready = !rst && (!out_valid[in_sel] || out_ready[in_sel]). This is combinational from in_sel, out_valid and out_ready. It must not depend on in_valid.
- Per channel i, on each clk edge (priority order):
  - Accept with in_sel==i: out_valid[i] <= 1, out_data_i <= in_data. This wins over a simultaneous drain, so the slot is refilled in the same cycle.
  - Else output transfer i: out_valid[i] <= 0; out_data_i holds its last value.
  - Else: hold.
- Latency and throughput:
  - Latency is 1 cycle: a beat accepted at edge k is visible on out_data_i with out_valid[i]=1 after edge k.
  - Sustained throughput is 1 beat/cycle to any single channel when its consumer holds ready high.
- Stability: while out_valid[i] && !out_ready[i], out_data_i and out_valid[i] must not change.
- Isolation:
  - A full channel blocks only beats addressed to it.
  - The producer may keep valid high and change in_sel/in_data while in_ready=0. The block does not require AXI-style hold, but must not accept the beat.
- Counters:
  - xfer_cnt_i increments by 1 on each output transfer i.
  - Wraps modulo 2^CNT_W: 2^CNT_W-1 goes to 0 with no saturation and no flag.
- Reset mid-operation: in-flight beats in the slots are discarded with no drain, and counters clear.
- No state machine beyond the four per-slot valid flags. Only one input beat is accepted per cycle.

Decomposition:
- Package stream_demux_pkg holds:
  - N_CH=4.
  - SEL_W=2.
  - typedef sel_t = logic [SEL_W-1:0].
- Sub-module stream_slot: one-entry register stage with a load input, a drain handshake, an output data register and a transfer counter. Instantiated 4 times via generate. The top level adds in_ready selection and load decode.

Test Plan:
- Reset release, then with all out_ready=1, send data 'ha,'hb,'hc,'hd with sel 0,1,2,3 on consecutive cycles -> each appears one cycle later on out_data0..3 with the matching out_valid bit; xfer_cnt0..3 = 1 each.
- out_ready[2]=0. Send 'h5 to ch2, then 'h6 to ch2, then 'h7 to ch1:
  - 'h5 is held on out_data2.
  - in_ready=0 while sel=2.
  - 'h7 reaches ch1 next cycle.
  - Releasing out_ready[2] lets 'h6 through.
- Stream 8 beats to ch3 back-to-back with out_ready[3]=1 -> in_ready stays 1, out_valid[3] stays 1 for 8 cycles, xfer_cnt3=8.
- CNT_W=8: drive 257 transfers to ch0 -> xfer_cnt0 = 1 (wrap checked at 255->0).
- Assert rst asynchronously (mid-cycle) with ch1 and ch2 full -> out_valid=0 and counters=0 immediately, in_ready=0 until release.
- in_valid=0 with in_sel='x -> no slot changes, out_valid and counters unchanged.
